aes_key_scheduler: RTL and testbench

Sequential AES-128 key-schedule controller: on a `start` pulse it captures a cipher key and steps a single key-expansion stage once per clock, producing round keys 0..10 into an internal 11-entry key store. A registered read port lets the round pipeline or cipher FSM fetch any round key by index. One shared expansion stage is used for all rounds, so this block fully owns the round counter, Rcon sequencing and key-valid status.

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/aes_key_scheduler_if.sv | 26 ++
 rtl/aes_key_step.sv | 24 ++
 rtl/aes_key_scheduler.sv | 99 +++++++++
 tb/tb_aes_key_scheduler.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// AES-128 constants and helpers shared by the key-schedule blocks.
package aes_pkg;

  localparam int unsigned AES_NR     = 10;
  localparam int unsigned AES_KEY_W  = 128;
  localparam int unsigned AES_RND_W  = 4;

  typedef logic [AES_KEY_W-1:0] aes_key_t;

  // Forward S-box, entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constants; index 0 is unused padding so rounds index directly.
  localparam logic [0:10][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Byte-wise S-box substitution of a 32-bit word.
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_key_scheduler_if.sv
// Control and read-port bundle between the cipher FSM and the key scheduler.
interface aes_key_scheduler_if;
  import aes_pkg::*;

  logic                 start;
  aes_key_t             key_in;
  logic                 busy;
  logic                 done;
  logic                 key_valid;
  logic                 rd_en;
  logic [AES_RND_W-1:0] rd_round;
  aes_key_t             rd_key;
  logic                 rd_valid;
  logic                 rd_err;

  modport master (
    output start, key_in, rd_en, rd_round,
    input  busy, done, key_valid, rd_key, rd_valid, rd_err
  );

  modport slave (
    input  start, key_in, rd_en, rd_round,
    output busy, done, key_valid, rd_key, rd_valid, rd_err
  );

endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion round: round key k-1 -> round key k.
module aes_key_step
  import aes_pkg::*;
(
  input  aes_key_t    prev_key,
  input  logic [7:0]  rcon,
  output aes_key_t    next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev_key;

  // RotWord, SubWord and Rcon injection on the last word, then the XOR chain.
  assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_scheduler.sv
// Sequential AES-128 key schedule: one expansion step per cycle into an
// 11-entry flop key store with a registered, legality-checked read port.
module aes_key_scheduler
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  aes_key_scheduler_if.slave   bus
);

  typedef enum logic {ST_IDLE, ST_EXPAND} state_e;

  state_e               state_q;
  logic [AES_RND_W-1:0] cnt_q;
  aes_key_t             rk_q [AES_NR+1];
  logic                 busy_q, done_q, key_valid_q;
  aes_key_t             rd_key_q;
  logic                 rd_valid_q, rd_err_q;

  logic [AES_RND_W-1:0] prev_idx_c;
  logic [AES_RND_W-1:0] rd_idx_c;
  logic                 rd_ok_c;
  aes_key_t             next_key_c;

  // Source round for the shared expansion stage (guarded for cnt = 0).
  assign prev_idx_c = (cnt_q == '0) ? '0 : cnt_q - AES_RND_W'(1);

  aes_key_step u_step (
    .prev_key (rk_q[prev_idx_c]),
    .rcon     (RCON[cnt_q]),
    .next_key (next_key_c)
  );

  // Read legality uses the pre-edge round counter and valid flag.
  assign rd_ok_c  = (bus.rd_round <= AES_RND_W'(AES_NR)) &&
                    (key_valid_q || (bus.rd_round < cnt_q));
  assign rd_idx_c = rd_ok_c ? bus.rd_round : '0;

  // Expansion FSM: owns round counter, key store, busy/done/key_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      for (int i = 0; i <= int'(AES_NR); i++) rk_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            rk_q[0]     <= bus.key_in;
            cnt_q       <= AES_RND_W'(1);
            key_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          rk_q[cnt_q] <= next_key_c;
          if (cnt_q == AES_RND_W'(AES_NR)) begin
            done_q      <= 1'b1;
            key_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + AES_RND_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Registered read port; rd_key holds when no request is made.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else if (bus.rd_en) begin
      rd_key_q   <= rd_ok_c ? rk_q[rd_idx_c] : '0;
      rd_valid_q <= rd_ok_c;
      rd_err_q   <= !rd_ok_c;
    end else begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.key_valid = key_valid_q;
  assign bus.rd_key    = rd_key_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_err    = rd_err_q;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Directed FIPS-197 vector bench for the AES-128 key scheduler.
module tb_aes_key_scheduler;
  import aes_pkg::*;

  localparam aes_key_t K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_key_t K1_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam aes_key_t K1_RK2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam aes_key_t K1_RK3 = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam aes_key_t K1_RK10= 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam aes_key_t K2     = 128'hffeeddccbbaa99887766554433221100;
  localparam aes_key_t K3     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam aes_key_t K3_RK10= 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  aes_key_scheduler_if u_if ();

  aes_key_scheduler u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until done, counting edges since the start edge; expects 10.
  task automatic wait_done(input int already, input string tag);
    int n;
    n = already;
    while (!u_if.done && n < 20) begin
      tick();
      n++;
    end
    check(tag, 128'(n), 128'(10));
  endtask

  // Single-cycle read request; result is checked by the caller.
  task automatic rd(input logic [3:0] rnd);
    u_if.rd_en    = 1'b1;
    u_if.rd_round = rnd;
    tick();
    u_if.rd_en    = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    u_if.start    = 1'b0;
    u_if.key_in   = '0;
    u_if.rd_en    = 1'b0;
    u_if.rd_round = '0;
    rst = 1'b1;
    #12;
    check("rst_busy",  128'(u_if.busy), 128'(0));
    check("rst_done",  128'(u_if.done), 128'(0));
    check("rst_kv",    128'(u_if.key_valid), 128'(0));
    check("rst_rdkey", u_if.rd_key, '0);
    check("rst_rdv",   128'(u_if.rd_valid), 128'(0));
    check("rst_rderr", 128'(u_if.rd_err), 128'(0));
    rst = 1'b0;
    tick();

    // Run A: FIPS key, early reads, ignored start at E4.
    u_if.start  = 1'b1;
    u_if.key_in = K1;
    tick();                                   // E0
    u_if.start  = 1'b0;
    check("a_busy", 128'(u_if.busy), 128'(1));
    tick();                                   // E1
    rd(4'd1);                                 // E2
    check("early_rk1_v", 128'(u_if.rd_valid), 128'(1));
    check("early_rk1",   u_if.rd_key, K1_RK1);
    rd(4'd5);                                 // E3
    check("early_rk5_err", 128'(u_if.rd_err), 128'(1));
    check("early_rk5_key", u_if.rd_key, '0);
    u_if.start  = 1'b1;
    u_if.key_in = K2;
    tick();                                   // E4, ignored
    u_if.start  = 1'b0;
    wait_done(4, "a_latency");
    check("a_kv", 128'(u_if.key_valid), 128'(1));
    check("a_busy_lo", 128'(u_if.busy), 128'(0));

    // Re-key in the done cycle with a concurrent read of the old rk10.
    u_if.start    = 1'b1;
    u_if.key_in   = K1;
    u_if.rd_en    = 1'b1;
    u_if.rd_round = 4'd10;
    tick();                                   // E0'
    u_if.start    = 1'b0;
    u_if.rd_en    = 1'b0;
    check("a_rk10_old", u_if.rd_key, K1_RK10);
    check("rekey_kv",   128'(u_if.key_valid), 128'(0));
    check("rekey_busy", 128'(u_if.busy), 128'(1));
    check("done_pulse", 128'(u_if.done), 128'(0));
    rd(4'd3);                                 // E1'
    check("rekey_rk3_err", 128'(u_if.rd_err), 128'(1));
    tick();                                   // E2'
    tick();                                   // E3'
    rd(4'd3);                                 // E4'
    check("rekey_rk3_v", 128'(u_if.rd_valid), 128'(1));
    check("rekey_rk3",   u_if.rd_key, K1_RK3);
    wait_done(4, "b_latency");

    // Post-done reads.
    rd(4'd0);
    check("rk0", u_if.rd_key, K1);
    rd(4'd1);
    check("rk1", u_if.rd_key, K1_RK1);
    rd(4'd2);
    check("rk2", u_if.rd_key, K1_RK2);
    rd(4'd10);
    check("rk10", u_if.rd_key, K1_RK10);
    tick();
    check("hold_key", u_if.rd_key, K1_RK10);
    check("hold_v",   128'(u_if.rd_valid), 128'(0));
    rd(4'd11);
    check("idx11_err", 128'(u_if.rd_err), 128'(1));
    check("idx11_v",   128'(u_if.rd_valid), 128'(0));
    check("idx11_key", u_if.rd_key, '0);
    rd(4'd15);
    check("idx15_err", 128'(u_if.rd_err), 128'(1));
    check("idx15_v",   128'(u_if.rd_valid), 128'(0));

    // Reset mid-expansion at E5, then a clean run with K3.
    u_if.start  = 1'b1;
    u_if.key_in = K3;
    tick();                                   // E0
    u_if.start  = 1'b0;
    rd(4'd0);                                 // E1, leaves rd_key nonzero
    repeat (4) tick();                        // E2..E5
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 128'(u_if.busy), 128'(0));
    check("mid_rst_kv",   128'(u_if.key_valid), 128'(0));
    check("mid_rst_key",  u_if.rd_key, '0);
    rst = 1'b0;
    rd(4'd0);
    check("post_rst_rk0_err", 128'(u_if.rd_err), 128'(1));
    u_if.start  = 1'b1;
    u_if.key_in = K3;
    tick();                                   // E0
    u_if.start  = 1'b0;
    wait_done(0, "c_latency");
    rd(4'd10);
    check("k3_rk10", u_if.rd_key, K3_RK10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
